// File: rtl/i2c_status.sv
// ---------------------------------------------------------------------------
// i2c_status
//
// Producer side of the I2C status vector. Event pulses from the byte engine
// are latched into sticky, write-1-to-clear bits. The raw SCL/SDA pins are
// synchronised and decoded into START/STOP pulses and a bus-busy bit. The
// status vector is a pure register output and feeds the interrupt combiner
// and the CPU read mux.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   scl_i      raw SCL pin level (asynchronous)
//   sda_i      raw SDA pin level (asynchronous)
//   ev_td      pulse: byte transfer done            -> sticky bit0
//   ev_af      pulse: arbitration lost              -> sticky bit1
//   ev_na      pulse: no acknowledge received       -> sticky bit2
//   ev_rx      pulse: rx byte written to data reg   -> sets RXF (bit5)
//   rx_rd      pulse: CPU read of rx data register  -> clears RXF
//   tip        level: transfer in progress          -> bit4 (registered)
//   txe        level: transmit data register empty  -> bit6 (registered)
//   wr_en      CPU write strobe to the status register
//   wr_data    CPU write data, a 1 clears the matching sticky bit
//   status     {2'b00, OVR, TXE, RXF, TIP, BB, NA, AF, TD}
//   start_det  one-cycle pulse on START / repeated START
//   stop_det   one-cycle pulse on STOP
// ---------------------------------------------------------------------------
module i2c_status #(
    parameter int SYNC_STAGES = 2,
    parameter int STS_W       = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scl_i,
    input  logic             sda_i,
    input  logic             ev_td,
    input  logic             ev_af,
    input  logic             ev_na,
    input  logic             ev_rx,
    input  logic             rx_rd,
    input  logic             tip,
    input  logic             txe,
    input  logic             wr_en,
    input  logic [STS_W-1:0] wr_data,
    output logic [STS_W-1:0] status,
    output logic             start_det,
    output logic             stop_det
);

    // Synchroniser chains; index SYNC_STAGES-1 is the synchronised output.
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;
    logic                   sda_p;

    logic start_cond;
    logic stop_cond;

    // Status storage bits.
    logic td_q, af_q, na_q, bb_q, tip_q, rxf_q, txe_q, ovr_q;
    logic td_d, af_d, na_d, bb_d, rxf_d, ovr_d;

    logic [STS_W-1:0] clr;

    // Only the sticky TD/AF/NA/OVR bits are writable.
    logic unused_wr_bits;
    assign unused_wr_bits = ^{wr_data[STS_W-1:8], wr_data[6:3]};

    // Synchronisers and previous-SDA flop reset high so that releasing reset
    // on an idle bus never looks like an SDA edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            sda_p    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            sda_p    <= sda_s;
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // SDA edges only count while SCL is high; otherwise they are data bits.
    assign start_cond = scl_s &  sda_p & ~sda_s;
    assign stop_cond  = scl_s & ~sda_p &  sda_s;

    assign clr = wr_en ? wr_data : '0;

    // Next-state of the stored bits. For sticky bits a set in the same cycle
    // as a clear wins. OVR fires only when a new byte lands on a full buffer
    // that is not being read in that same cycle.
    always_comb begin
        td_d  = td_q;
        af_d  = af_q;
        na_d  = na_q;
        bb_d  = bb_q;
        rxf_d = rxf_q;
        ovr_d = ovr_q;

        td_d  = ev_td | (td_q & ~clr[0]);
        af_d  = ev_af | (af_q & ~clr[1]);
        na_d  = ev_na | (na_q & ~clr[2]);
        rxf_d = ev_rx | (rxf_q & ~rx_rd);
        ovr_d = (ev_rx & rxf_q & ~rx_rd) | (ovr_q & ~clr[7]);

        if (start_cond) begin
            bb_d = 1'b1;
        end else if (stop_cond) begin
            bb_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            td_q      <= 1'b0;
            af_q      <= 1'b0;
            na_q      <= 1'b0;
            bb_q      <= 1'b0;
            tip_q     <= 1'b0;
            rxf_q     <= 1'b0;
            txe_q     <= 1'b0;
            ovr_q     <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            td_q      <= td_d;
            af_q      <= af_d;
            na_q      <= na_d;
            bb_q      <= bb_d;
            tip_q     <= tip;
            rxf_q     <= rxf_d;
            txe_q     <= txe;
            ovr_q     <= ovr_d;
            start_det <= start_cond;
            stop_det  <= stop_cond;
        end
    end

    assign status = {{(STS_W-8){1'b0}}, ovr_q, txe_q, rxf_q, tip_q,
                     bb_q, na_q, af_q, td_q};

endmodule

// File: tb/tb_i2c_status.sv
// ---------------------------------------------------------------------------
// tb_i2c_status
//
// Self-checking bench for i2c_status. A behavioural model keeps the expected
// status vector and derives START/STOP from a history of pin samples: a
// falling (rising) SDA with SCL high, seen SYNC_STAGES+1 edges later.
// Directed scenarios are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_i2c_status;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_i, sda_i;
    logic       ev_td, ev_af, ev_na, ev_rx, rx_rd;
    logic       tip, txe;
    logic       wr_en;
    logic [9:0] wr_data;
    logic [9:0] status;
    logic       start_det, stop_det;

    int check_count = 0;
    int error_count = 0;

    // Model state
    logic [9:0] exp_status;
    logic       exp_start, exp_stop;
    logic       scl_h[$];
    logic       sda_h[$];

    int n_start;

    i2c_status #(.SYNC_STAGES(S), .STS_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .ev_td     (ev_td),
        .ev_af     (ev_af),
        .ev_na     (ev_na),
        .ev_rx     (ev_rx),
        .rx_rd     (rx_rd),
        .tip       (tip),
        .txe       (txe),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .status    (status),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [9:0] observed,
                               input logic [9:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%03h, expected 0x%03h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        exp_status = '0;
        exp_start  = 1'b0;
        exp_stop   = 1'b0;
        scl_h = {};
        sda_h = {};
        repeat (S + 2) begin
            scl_h.push_back(1'b1);
            sda_h.push_back(1'b1);
        end
    endtask

    // One clock edge worth of behaviour, using the inputs held before it.
    task automatic modelEdge();
        logic [9:0] nxt;
        logic [9:0] c;
        int k;
        scl_h.push_back(scl_i);
        sda_h.push_back(sda_i);
        k = scl_h.size() - 1 - S;
        exp_start = scl_h[k] &&  !sda_h[k] &&  sda_h[k-1];
        exp_stop  = scl_h[k] &&   sda_h[k] && !sda_h[k-1];
        void'(scl_h.pop_front());
        void'(sda_h.pop_front());

        c   = wr_en ? wr_data : 10'h000;
        nxt = 10'h000;
        nxt[0] = ev_td | (exp_status[0] & ~c[0]);
        nxt[1] = ev_af | (exp_status[1] & ~c[1]);
        nxt[2] = ev_na | (exp_status[2] & ~c[2]);
        nxt[3] = exp_start ? 1'b1 : (exp_stop ? 1'b0 : exp_status[3]);
        nxt[4] = tip;
        nxt[5] = ev_rx | (exp_status[5] & ~rx_rd);
        nxt[6] = txe;
        nxt[7] = (ev_rx & exp_status[5] & ~rx_rd) | (exp_status[7] & ~c[7]);
        exp_status = nxt;
    endtask

    // Advance one clock, update the model, then check 1 time unit later.
    task automatic applyStimulus();
        @(posedge clk);
        if (rst_n) modelEdge();
        else       modelReset();
        #1;
        checkOutput("status",    status,                 exp_status);
        checkOutput("start_det", {9'b0, start_det},      {9'b0, exp_start});
        checkOutput("stop_det",  {9'b0, stop_det},       {9'b0, exp_stop});
    endtask

    task automatic clearPulses();
        ev_td = 0; ev_af = 0; ev_na = 0; ev_rx = 0; rx_rd = 0;
        wr_en = 0; wr_data = '0;
    endtask

    task automatic busStep(input bit check_bb);
        applyStimulus();
        n_start += int'(start_det);
        if (check_bb) checkOutput("bb_held", {9'b0, status[3]}, 10'h001);
    endtask

    initial begin
        rst_n = 1'b1;
        scl_i = 1'b1; sda_i = 1'b1;
        tip = 0; txe = 0;
        clearPulses();
        modelReset();

        // Reset with idle bus
        #3 rst_n = 1'b0;
        #1;
        checkOutput("reset_status", status, 10'h000);
        checkOutput("reset_pulses", {8'b0, start_det, stop_det}, 10'h000);
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            checkOutput("idle_no_pulse", {8'b0, start_det, stop_det}, 10'h000);
        end

        // Sticky TD set / clear / set-wins
        ev_td = 1; applyStimulus(); clearPulses();
        checkOutput("td_set", status, 10'h001);
        repeat (3) applyStimulus();
        wr_en = 1; wr_data = 10'h001; applyStimulus(); clearPulses();
        checkOutput("td_clr", status, 10'h000);
        ev_td = 1; wr_en = 1; wr_data = 10'h001; applyStimulus(); clearPulses();
        checkOutput("td_set_wins", status, 10'h001);
        wr_en = 1; wr_data = 10'h007; applyStimulus(); clearPulses();
        checkOutput("td_clr2", status, 10'h000);

        // RXF / OVR
        ev_rx = 1; applyStimulus(); clearPulses();
        checkOutput("rxf_set", status, 10'h020);
        repeat (2) applyStimulus();
        ev_rx = 1; applyStimulus(); clearPulses();
        checkOutput("ovr_set", status, 10'h0A0);
        ev_rx = 1; rx_rd = 1; applyStimulus(); clearPulses();
        checkOutput("rx_and_rd", status, 10'h0A0);
        wr_en = 1; wr_data = 10'h3FF; applyStimulus(); clearPulses();
        checkOutput("wr_3ff", status, 10'h020);
        rx_rd = 1; applyStimulus(); clearPulses();
        checkOutput("rxf_rd", status, 10'h000);

        // START with exact 3-cycle latency
        sda_i = 0;
        applyStimulus(); checkOutput("start_lat1", {9'b0, start_det}, 10'h000);
        applyStimulus(); checkOutput("start_lat2", {9'b0, start_det}, 10'h000);
        applyStimulus(); checkOutput("start_lat3", {9'b0, start_det}, 10'h001);
        checkOutput("bb_set", {9'b0, status[3]}, 10'h001);
        applyStimulus(); checkOutput("start_one", {9'b0, start_det}, 10'h000);

        // Data transitions while SCL low
        scl_i = 0; repeat (4) applyStimulus();
        for (int i = 0; i < 8; i++) begin
            sda_i = ~sda_i;
            applyStimulus();
            checkOutput("data_no_pulse", {8'b0, start_det, stop_det}, 10'h000);
        end
        sda_i = 0; repeat (4) applyStimulus();
        scl_i = 1; repeat (4) applyStimulus();
        checkOutput("bb_after_data", {9'b0, status[3]}, 10'h001);

        // STOP
        sda_i = 1;
        applyStimulus(); applyStimulus(); applyStimulus();
        checkOutput("stop_pulse", {9'b0, stop_det}, 10'h001);
        checkOutput("bb_clr", {9'b0, status[3]}, 10'h000);
        repeat (3) applyStimulus();

        // Repeated START
        n_start = 0;
        sda_i = 0;
        busStep(0); busStep(0); busStep(1); busStep(1); busStep(1);
        scl_i = 0; repeat (4) busStep(1);
        sda_i = 1; repeat (4) busStep(1);
        scl_i = 1; repeat (4) busStep(1);
        sda_i = 0; repeat (5) busStep(1);
        checkOutput("two_starts", 10'(n_start), 10'd2);

        // Reset mid-transfer
        tip = 1;
        applyStimulus();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset", status, 10'h000);
        modelReset();
        scl_i = 1; sda_i = 1; tip = 0;
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            checkOutput("bb_after_reset", {9'b0, status[3]}, 10'h000);
        end
        sda_i = 0; repeat (3) applyStimulus();
        checkOutput("bb_restart", {9'b0, status[3]}, 10'h001);
        sda_i = 1; repeat (4) applyStimulus();

        // TIP/TXE follow with one cycle latency
        for (int i = 0; i < 8; i++) begin
            tip = i[0];
            txe = ~i[0];
            applyStimulus();
            checkOutput("tip_follow", {9'b0, status[4]}, {9'b0, i[0]});
            checkOutput("txe_follow", {9'b0, status[6]}, {9'b0, ~i[0]});
        end
        tip = 1; txe = 1; applyStimulus();
        wr_en = 1; wr_data = 10'h358; applyStimulus(); clearPulses();
        checkOutput("wr_358", status, 10'h050);
        tip = 0; txe = 0; applyStimulus();

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            ev_td = ($urandom_range(7) == 0);
            ev_af = ($urandom_range(7) == 0);
            ev_na = ($urandom_range(7) == 0);
            ev_rx = ($urandom_range(3) == 0);
            rx_rd = ($urandom_range(4) == 0);
            tip   = 1'($urandom);
            txe   = 1'($urandom);
            wr_en = ($urandom_range(5) == 0);
            wr_data = 10'($urandom);
            if ($urandom_range(3) == 0) scl_i = ~scl_i;
            if ($urandom_range(2) == 0) sda_i = ~sda_i;
            if ($urandom_range(499) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                checkOutput("rand_async_reset", status, 10'h000);
                modelReset();
                applyStimulus();
                rst_n = 1'b1;
            end else begin
                applyStimulus();
            end
        end
        clearPulses();

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule

// File: doc/i2c_status.md
Name: i2c_status

Overview:
- Producer side of the I2C status vector.
- Collects event pulses from the I2C byte engine, plus the bus state decoded from the synchronised SCL/SDA pins.
- Holds them in a sticky, write-1-to-clear 10-bit status register.
- Its `status` output feeds the I2C interrupt combiner and the CPU register read mux.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on each of scl_i and sda_i; legal values 2..4.
- STS_W, 10, status vector width; fixed at 10.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- scl_i  input  1  raw SCL pin level (asynchronous).
- sda_i  input  1  raw SDA pin level (asynchronous).
- ev_td  input  1  one-cycle pulse: byte transfer done.
- ev_af  input  1  one-cycle pulse: arbitration lost.
- ev_na  input  1  one-cycle pulse: no acknowledge received.
- ev_rx  input  1  one-cycle pulse: received byte written to the data register.
- rx_rd  input  1  one-cycle pulse: CPU read of the receive data register.
- tip  input  1  live level: transfer in progress.
- txe  input  1  live level: transmit data register empty.
- wr_en  input  1  CPU write strobe to the status register.
- wr_data  input  10  CPU write data; a 1 clears the corresponding sticky bit.
- status  output  10  status vector.
- start_det  output  1  one-cycle pulse on detected START / repeated START.
- stop_det  output  1  one-cycle pulse on detected STOP.

Behaviour:
- Status layout, matching the shared I2C definitions:
  - bit0 STS_TD, sticky.
  - bit1 STS_AF, sticky.
  - bit2 STS_NA, sticky.
  - bit3 STS_BB, bus busy, state bit.
  - bit4 STS_TIP, live copy of tip, registered.
  - bit5 STS_RXF, rx full, sticky.
  - bit6 STS_TXE, live copy of txe, registered.
  - bit7 STS_OVR, rx overrun, sticky.
  - bits9:8 reserved, always 0.
- Reset values:
  - status = 10'h000; start_det = stop_det = 0.
  - Synchroniser flops and the previous-level flops reset to 1 (idle bus high), so reset release with the bus idle produces no spurious START/STOP.
- Sticky bits TD, AF, NA, OVR:
  - Event pulse in cycle N sets the bit; status shows 1 from cycle N+1.
  - wr_en with wr_data[i]=1 clears bit i in the next cycle; wr_data[i]=0 leaves it unchanged.
  - Set and clear in the same cycle: set wins, bit stays 1.
- RXF:
  - Set by ev_rx; cleared only by rx_rd.
  - Writes to bit5 are ignored.
  - ev_rx and rx_rd in the same cycle: RXF = 1, OVR unchanged.
- OVR: set when ev_rx arrives while RXF=1 and rx_rd is not asserted in that cycle.
- TIP, TXE: registered copies of tip and txe, 1-cycle latency. Writes are ignored.
- Bus monitor:
  - scl_s and sda_s are the outputs of SYNC_STAGES-deep synchronisers; sda_p is sda_s delayed by one cycle.
  - START: scl_s=1, sda_p=1, sda_s=0. Drives start_det=1 for one cycle and sets BB.
  - STOP: scl_s=1, sda_p=0, sda_s=1. Drives stop_det=1 for one cycle and clears BB.
  - Latency from pin edge to pulse is SYNC_STAGES+1 cycles, i.e. 3 at the default.
  - A repeated START while BB=1 pulses start_det; BB stays 1.
  - SDA changes while scl_s=0 are data transitions: no detection.
  - Writes to BB are ignored.
- Reset asserted mid-operation forces all state to its reset values immediately. After reset BB=0 even if a transfer was in flight; BB is set again only by the next detected START.
- Reserved bits read 0 regardless of wr_data.
- No combinational path from any input to status; status is a pure register output.

Test Plan:
- Reset with scl_i=sda_i=1, then release → status=10'h000, no start_det/stop_det pulse over 20 cycles.
- ev_td pulse at cycle 10 → status[0]=1 at cycle 11. wr_en with wr_data=10'h001 at cycle 15 → status[0]=0 at cycle 16. Repeat with ev_td and the clear in the same cycle → status[0] stays 1.
- ev_rx at cycle 5 → RXF=1. ev_rx at cycle 8 with no rx_rd → OVR=1, status=10'h0A0. ev_rx and rx_rd together at cycle 12 → RXF stays 1, no further change. Write 10'h3FF → only OVR clears, status=10'h020.
- With scl_i=1, drive sda_i 1→0 → start_det pulse exactly 3 cycles later, BB=1. Toggle sda_i with scl_i=0 → no pulses. sda_i 0→1 with scl_i=1 → stop_det pulse, BB=0.
- START, then a second START without a STOP → two start_det pulses, BB=1 throughout. Assert rst_n=0 mid-transfer → status=10'h000 asynchronously, BB stays 0 until the next START.
- tip and txe toggled each cycle → status[4] and status[6] follow with exactly 1-cycle latency. wr_en with wr_data=10'h358 leaves bits 3, 4, 6 and reserved bits 9:8 unaffected.
